// File: rtl/load_store_unit_if.sv
// Request/response and byte-memory bus between a core, the load/store unit and data memory.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_func3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V style load/store unit: splits B/H/W accesses into sequential byte accesses
// on an 8-bit memory and returns one sign/zero-extended response per request.
module load_store_unit #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        func3_q, func3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [31:0]       data_q, data_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        rd_idx_q, rd_idx_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              req_err_c;
    logic              unused_addr_c;

    assign unused_addr_c = ^bus.req_addr[31:ADDR_W];

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'h0, d[7:0]};
            3'b101:  r = {16'h0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Illegal funct3, signed-store encodings and misaligned halfword/word accesses
    always_comb begin
        req_err_c = 1'b0;
        case (bus.req_func3)
            3'b011, 3'b110, 3'b111: req_err_c = 1'b1;
            default:                req_err_c = 1'b0;
        endcase
        if (bus.req_we && bus.req_func3[2])                          req_err_c = 1'b1;
        if (bus.req_func3[1:0] == 2'b01 && bus.req_addr[0])          req_err_c = 1'b1;
        if (bus.req_func3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err_c = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        func3_d      = func3_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_pend_d    = mem_re_q;
        rd_idx_d     = cnt_q;
        data_d       = data_q;
        // Read data arrives the cycle after its mem_re cycle
        if (rd_pend_q) data_d[{rd_idx_q, 3'b000} +: 8] = bus.mem_rdata;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    func3_d = bus.req_func3;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 2'd0;
                    data_d  = 32'h0;
                    case (bus.req_func3[1:0])
                        2'b01:   last_d = 2'd1;
                        2'b10:   last_d = 2'd3;
                        default: last_d = 2'd0;
                    endcase
                    if (req_err_c) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        state_d     = ISSUE;
                        mem_addr_d  = bus.req_addr[ADDR_W-1:0];
                        mem_wdata_d = bus.req_wdata[7:0];
                        mem_we_d    = bus.req_we;
                        mem_re_d    = ~bus.req_we;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == last_q) begin
                    state_d = we_q ? RESP : DRAIN;
                    if (we_q) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0;
                    end
                end else begin
                    cnt_d       = cnt_q + 2'd1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    mem_wdata_d = wdata_q[{cnt_d, 3'b000} +: 8];
                    mem_we_d    = we_q;
                    mem_re_d    = ~we_q;
                end
            end
            DRAIN: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = extend(func3_q, data_d);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            func3_q      <= 3'b000;
            wdata_q      <= 32'h0;
            cnt_q        <= 2'd0;
            last_q       <= 2'd0;
            data_q       <= 32'h0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            func3_q      <= func3_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            data_q       <= data_d;
            rd_pend_q    <= rd_pend_d;
            rd_idx_q     <= rd_idx_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a synchronous-read byte memory model.
module tb_load_store_unit;

    localparam int unsigned ADDR_W = 6;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   strobe_cnt = 0;

    resp_t rq[$];
    wr_t   wq[$];
    logic [7:0] mem [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte memory: write on the strobe edge, read data valid the following cycle
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        wr_t   w;
        if (bus.mem_re || bus.mem_we) begin
            strobe_cnt++;
            check("strobe_exclusive", 32'(bus.mem_re & bus.mem_we), 32'd0);
        end
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = wq.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(w.data));
            end
        end
        if (bus.resp_valid) begin
            if (rq.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                check({e.tag, "_err"},   32'(bus.resp_err), 32'(e.err));
                check({e.tag, "_rdata"}, bus.resp_rdata,   e.rdata);
                check({e.tag, "_cycle"}, 32'(cyc),         32'(e.cyc));
            end
        end
    end

    // Present a request at a negedge, wait until accepted, record expectations
    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata, input int lat,
                         input int n_wr, input bit hold, input bit expect_resp,
                         output int waits);
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        waits = 0;
        while (!bus.req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!bus.req_ready) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        if (expect_resp) rq.push_back('{tag, err, rdata, cyc + lat});
        for (int k = 0; k < n_wr; k++)
            wq.push_back('{ADDR_W'(addr + 32'(k)), wdata[8*k +: 8]});
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((rq.size() != 0 || wq.size() != 0 || !bus.req_ready) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain"}, 32'(t < 50), 32'd1);
    endtask

    initial begin
        int w;
        int sc;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_func3 = 3'b000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req_ready",  32'(bus.req_ready),  32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err",   32'(bus.resp_err),   32'd0);
        check("rst_resp_rdata", bus.resp_rdata,      32'd0);
        check("rst_mem_re",     32'(bus.mem_re),     32'd0);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
        check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("sw08", 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0, 5, 4, 1'b0, 1'b1, w);
        drain("sw08");
        issue("lb09",  1'b0, 3'b000, 32'h09, 32'h0, 1'b0, 32'hFFFFFFBE, 3, 0, 1'b0, 1'b1, w);
        issue("lbu09", 1'b0, 3'b100, 32'h09, 32'h0, 1'b0, 32'h000000BE, 3, 0, 1'b0, 1'b1, w);
        issue("lh0a",  1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, 32'hFFFFDEAD, 4, 0, 1'b0, 1'b1, w);
        issue("lhu0a", 1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, 32'h0000DEAD, 4, 0, 1'b0, 1'b1, w);
        issue("lw08",  1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 6, 0, 1'b0, 1'b1, w);
        drain("loads");

        sc = strobe_cnt;
        issue("lw0a_mis",  1'b0, 3'b010, 32'h0A, 32'h0,    1'b1, 32'h0, 1, 0, 1'b0, 1'b1, w);
        issue("sh_f3_101", 1'b1, 3'b101, 32'h20, 32'h1234, 1'b1, 32'h0, 1, 0, 1'b0, 1'b1, w);
        issue("f3_011",    1'b0, 3'b011, 32'h00, 32'h0,    1'b1, 32'h0, 1, 0, 1'b0, 1'b1, w);
        issue("lh_odd",    1'b0, 3'b001, 32'h0B, 32'h0,    1'b1, 32'h0, 1, 0, 1'b0, 1'b1, w);
        drain("errors");
        check("err_no_strobes", 32'(strobe_cnt - sc), 32'd0);

        issue("sw3c_old", 1'b1, 3'b010, 32'h3C, 32'hAABBCCDD, 1'b0, 32'h0, 5, 4, 1'b0, 1'b1, w);
        drain("sw3c_old");
        // Second store is cut off by reset after its second byte
        issue("sw3c_rst", 1'b1, 3'b010, 32'h3C, 32'h11223344, 1'b0, 32'h0, 5, 2, 1'b0, 1'b0, w);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_we",     32'(bus.mem_we),     32'd0);
        check("abort_mem_re",     32'(bus.mem_re),     32'd0);
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_req_ready",  32'(bus.req_ready),  32'd1);
        rst = 1'b0;
        @(negedge clk);
        issue("lw3c", 1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'hAABB3344, 6, 0, 1'b0, 1'b1, w);
        drain("lw3c");

        issue("b2b_sw", 1'b1, 3'b010, 32'h10, 32'h01020304, 1'b0, 32'h0, 5, 4, 1'b1, 1'b1, w);
        check("b2b_first_waits", 32'(w), 32'd0);
        issue("b2b_lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h01020304, 6, 0, 1'b0, 1'b1, w);
        check("b2b_second_waits", 32'(w), 32'd5);
        issue("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'h00000003, 3, 0, 1'b0, 1'b1, w);
        issue("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h00000102, 4, 0, 1'b0, 1'b1, w);
        drain("tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, width of the byte address driven to data memory (64-byte memory).
REQ-002 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have req_valid  in  1  core presents a memory request.
REQ-005 SHALL have req_ready  out  1  unit can accept a request.
REQ-006 SHALL have req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have req_func3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have req_addr  in  32  byte address; bits above ADDR_W-1 ignored.
REQ-009 SHALL have req_wdata  in  32  store data, little-endian byte order.
REQ-010 SHALL have resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have resp_err  out  1  qualifies resp_valid: misaligned or illegal request.
REQ-012 SHALL have resp_rdata  out  32  extended load data, valid with resp_valid.
REQ-013 SHALL have mem_re, mem_we  out  1 each  byte-memory read/write strobes.
REQ-014 SHALL have mem_addr  out  ADDR_W  byte address; mem_wdata  out  8  write byte.
REQ-015 SHALL have mem_rdata  in  8  read byte, valid the cycle after the mem_re cycle.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on the edge where req_valid & req_ready; latch we, func3, addr, wdata; byte count N = 1/2/4 for size 00/01/10.
REQ-018 SHALL flag an error when func3 is 011, 110 or 111, when a store has func3[2] = 1, when a halfword has addr[0] = 1, or when a word has addr[1:0] != 00.
REQ-019 SHALL, on error, go IDLE->RESP with no mem_re/mem_we activity, then pulse resp_valid = 1, resp_err = 1, resp_rdata = 0.
REQ-020 SHALL, in ISSUE, drive exactly one byte access per cycle for N consecutive cycles (k = 0..N-1), with mem_addr = addr[ADDR_W-1:0] + k modulo 2^ADDR_W.
REQ-021 SHALL, for stores, assert mem_we with mem_wdata = req_wdata[8k+7:8k] and keep mem_re = 0.
REQ-022 SHALL, for loads, assert mem_re with mem_we = 0, and capture mem_rdata into result byte k one cycle after byte k is issued.
REQ-023 SHALL, for stores, go ISSUE->RESP after byte N-1; resp_valid is asserted in cycle N+1 after acceptance.
REQ-024 SHALL, for loads, go ISSUE->DRAIN->RESP; resp_valid is asserted in cycle N+2 after acceptance.
REQ-025 SHALL sign-extend loads from the top loaded bit for B/H and zero-extend for BU/HU; W passes through unchanged.
REQ-026 SHALL return RESP->IDLE after one cycle; resp_valid and resp_err are otherwise 0. resp_rdata for stores = 0.
REQ-027 SHALL drive mem_re = mem_we = 0 outside ISSUE and never assert both in the same cycle.
REQ-028 SHALL apply no backpressure on responses; the next request can be accepted in the cycle after RESP.

Reset
REQ-029 SHALL, when rst = 1 at an edge, enter IDLE and clear req_ready->1, resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_addr and mem_wdata to 0.
REQ-030 SHALL abort an in-flight request on reset with no response; bytes already written are not restored. rst has priority over a simultaneous request.

Verification
REQ-031 SHALL cover: SW addr 0x08, wdata 0xDEADBEEF -> mem_we for 4 cycles at addresses 8..11 with bytes EF,BE,AD,DE; resp_valid in cycle 5, resp_err = 0.
REQ-032 SHALL cover: LB addr 0x09 with mem[9] = 0xBE -> resp_rdata 0xFFFFFFBE; LBU -> 0x000000BE; resp_valid in cycle 3.
REQ-033 SHALL cover: LH addr 0x0A with mem[10..11] = AD,DE -> resp_rdata 0xFFFFDEAD; LHU -> 0x0000DEAD; LW addr 0x08 -> 0xDEADBEEF in cycle 6.
REQ-034 SHALL cover: LW addr 0x0A, and SH with func3 101 -> resp_err = 1 in cycle 1, resp_rdata = 0, no strobes.
REQ-035 SHALL cover: rst during the second byte of SW addr 0x3C -> strobes 0 from the next cycle, no resp_valid, req_ready = 1; the following LW addr 0x3C returns bytes 0..1 new and bytes 2..3 old.
REQ-036 SHALL cover: back-to-back requests with req_valid held high -> req_ready low during ISSUE, DRAIN and RESP; the second request is accepted in the cycle after RESP.
